// File: rtl/aes_inv_cipher_core_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 inverse cipher core.
package aes_inv_cipher_core_pkg;

   localparam int AES_NR       = 10;
   localparam int AES_BLK_W    = 128;
   localparam int AES_RK_DEPTH = AES_NR + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      KEXP = 2'd1,
      RUN  = 2'd2
   } state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Forward S-box for the key schedule: multiplicative inverse (a^254) then the affine map.
   function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = rk;
      t  = {sbox_fwd(w3[23:16]), sbox_fwd(w3[15:8]), sbox_fwd(w3[7:0]), sbox_fwd(w3[31:24])}
           ^ {rc, 24'h000000};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
      return o;
   endfunction

   // Byte (r,c) lives at index 4c+r; row r rotates right by r columns.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_cipher_core_sbox.sv
// AES inverse S-box: combinational 256-entry byte lookup.
module aes_inv_cipher_core_sbox
   import aes_inv_cipher_core_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] s
);

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   logic [10:0] idx_s;

   assign idx_s = 11'd2047 - {a, 3'b000};
   assign s     = INV_SBOX[idx_s -: 8];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// AES-128 iterative decryption core: forward key expansion into an 11-entry
// round-key buffer on kld, then one inverse round per clock per block.
module aes_inv_cipher_core
   import aes_inv_cipher_core_pkg::*;
#(
   parameter int NR       = AES_NR,
   parameter int RK_DEPTH = NR + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 kld,
   input  logic [AES_BLK_W-1:0] key,
   input  logic                 ld,
   input  logic [AES_BLK_W-1:0] text_in,
   output logic                 ready,
   output logic                 kdone,
   output logic                 done,
   output logic [AES_BLK_W-1:0] text_out
);

   if (NR != AES_NR || RK_DEPTH != AES_RK_DEPTH) begin : g_nr_check
      $error("aes_inv_cipher_core supports only AES-128 (NR=10, RK_DEPTH=11)");
   end

   localparam logic [3:0] KEXP_END  = 4'(RK_DEPTH);
   localparam logic [3:0] FIRST_RND = 4'(NR - 1);
   localparam logic [3:0] RK_TOP    = 4'(NR);

   state_e               fsm_r;
   logic                 key_valid_r;
   logic                 init_r;
   logic [3:0]           kcnt_r;
   logic [3:0]           rnd_r;
   logic [AES_BLK_W-1:0] kreg_r;
   logic [AES_BLK_W-1:0] state_r;
   logic [AES_BLK_W-1:0] rk_buf_r [RK_DEPTH];

   logic [AES_BLK_W-1:0] isr_s;
   logic [AES_BLK_W-1:0] isb_s;
   logic [AES_BLK_W-1:0] ark_s;
   logic [AES_BLK_W-1:0] mix_s;
   logic [AES_BLK_W-1:0] key_next_s;

   for (genvar g = 0; g < 16; g++) begin : g_sbox
      aes_inv_cipher_core_sbox u_sbox (
         .a (isr_s[127-8*g -: 8]),
         .s (isb_s[127-8*g -: 8])
      );
   end

   // Round datapath and next round key from the expander register.
   always_comb begin
      isr_s      = inv_shift_rows(state_r);
      ark_s      = isb_s ^ rk_buf_r[rnd_r];
      mix_s      = inv_mix_cols(ark_s);
      key_next_s = key_next(kreg_r, rcon(kcnt_r));
   end

   // Control FSM with key buffer, round state and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm_r       <= IDLE;
         key_valid_r <= 1'b0;
         init_r      <= 1'b0;
         kcnt_r      <= 4'd0;
         rnd_r       <= 4'd0;
         kreg_r      <= 128'h0;
         state_r     <= 128'h0;
         ready       <= 1'b0;
         kdone       <= 1'b0;
         done        <= 1'b0;
         text_out    <= 128'h0;
         for (int i = 0; i < RK_DEPTH; i++) rk_buf_r[i] <= 128'h0;
      end else begin
         kdone <= 1'b0;
         done  <= 1'b0;
         if (kld) begin
            // A new key always wins: abandons any block and invalidates the buffer.
            fsm_r       <= KEXP;
            key_valid_r <= 1'b0;
            ready       <= 1'b0;
            init_r      <= 1'b0;
            kreg_r      <= key;
            kcnt_r      <= 4'd0;
            rnd_r       <= 4'd0;
         end else begin
            case (fsm_r)
               IDLE: begin
                  if (ld && key_valid_r) begin
                     state_r <= text_in;
                     init_r  <= 1'b1;
                     rnd_r   <= FIRST_RND;
                     ready   <= 1'b0;
                     fsm_r   <= RUN;
                  end
               end
               KEXP: begin
                  if (kcnt_r == KEXP_END) begin
                     key_valid_r <= 1'b1;
                     kdone       <= 1'b1;
                     ready       <= 1'b1;
                     kcnt_r      <= 4'd0;
                     fsm_r       <= IDLE;
                  end else begin
                     rk_buf_r[kcnt_r] <= kreg_r;
                     kreg_r           <= key_next_s;
                     kcnt_r           <= kcnt_r + 4'd1;
                  end
               end
               RUN: begin
                  if (init_r) begin
                     state_r <= state_r ^ rk_buf_r[RK_TOP];
                     init_r  <= 1'b0;
                  end else if (rnd_r != 4'd0) begin
                     state_r <= mix_s;
                     rnd_r   <= rnd_r - 4'd1;
                  end else begin
                     // Final round has no InvMixColumns and uses rk0.
                     text_out <= ark_s;
                     done     <= 1'b1;
                     ready    <= 1'b1;
                     fsm_r    <= IDLE;
                  end
               end
               default: begin
                  fsm_r <= IDLE;
                  ready <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Self-checking bench for aes_inv_cipher_core: FIPS-197 vectors, protocol corner
// cases and a random loopback against an independent forward-cipher model.
module tb_aes_inv_cipher_core;

   logic         clk = 1'b0;
   logic         rst;
   logic         kld;
   logic         ld;
   logic [127:0] key;
   logic [127:0] text_in;
   logic         ready;
   logic         kdone;
   logic         done;
   logic [127:0] text_out;

   int           checks = 0;
   int           failures = 0;
   logic [127:0] exp_q [$];
   logic [127:0] mon_exp;
   logic [127:0] last_pt = 128'h0;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

   localparam logic [2047:0] SBOX_T = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   always #5 clk = ~clk;

   aes_inv_cipher_core dut (
      .clk      (clk),
      .rst      (rst),
      .kld      (kld),
      .key      (key),
      .ld       (ld),
      .text_in  (text_in),
      .ready    (ready),
      .kdone    (kdone),
      .done     (done),
      .text_out (text_out)
   );

   function automatic logic [7:0] tb_sb(input logic [7:0] b);
      logic [2047:0] t;
      t = SBOX_T;
      return t[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [7:0] tb_xt(input logic [7:0] b);
      return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
   endfunction

   // Forward AES-128 encryption reference used to build loopback ciphertexts.
   function automatic logic [127:0] tb_encrypt(input logic [127:0] k, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tb_sb(tmp[23:16]), tb_sb(tmp[15:8]), tb_sb(tmp[7:0]), tb_sb(tmp[31:24])}
                  ^ {rc, 24'h000000};
            rc  = tb_xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = tb_sb(s[4*(((i/4) + (i%4)) % 4) + (i%4)]);
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (rnd < 10) begin
               s[4*c]   = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
               s[4*c+3] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      end
      o = 128'h0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // Scoreboard: every done must match the oldest outstanding plaintext.
   always @(negedge clk) begin
      if (rst === 1'b1 && done === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done text_out=%h required=no done", text_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (text_out !== mon_exp) begin
               failures++;
               $display("FAIL text_out got=%h want=%h", text_out, mon_exp);
            end
         end
      end
   end

   task automatic do_reset;
      rst = 1'b0; kld = 1'b0; ld = 1'b0; key = 128'h0; text_in = 128'h0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({ready, kdone, done} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b want=000", {ready, kdone, done});
      end
      checks++;
      if (text_out !== 128'h0) begin
         failures++;
         $display("FAIL reset_text_out got=%h want=0", text_out);
      end
   endtask

   task automatic test_ld_ignored(input string tag);
      bit saw;
      saw = 1'b0;
      ld = 1'b1; text_in = CT_C1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         ld = 1'b0;
         if (done === 1'b1 || ready === 1'b1 || kdone === 1'b1) saw = 1'b1;
      end
      checks++;
      if (saw) begin
         failures++;
         $display("FAIL %s_ld_ignored got=activity want=idle ready=0", tag);
      end
   endtask

   // ld_at: -1 none, 0 together with kld, >0 that many edges into the expansion.
   task automatic load_key(input logic [127:0] k, input int ld_at, input string tag);
      int lat;
      bit early_ready;
      early_ready = 1'b0;
      kld = 1'b1; key = k;
      ld = (ld_at == 0); text_in = CT_C1;
      @(negedge clk);
      kld = 1'b0;
      lat = 0;
      do begin
         ld = (ld_at > 0 && lat == ld_at);
         @(negedge clk);
         lat++;
         if (kdone !== 1'b1 && ready !== 1'b0) early_ready = 1'b1;
      end while (kdone !== 1'b1 && lat < 30);
      ld = 1'b0;
      checks++;
      if (lat != 12) begin
         failures++;
         $display("FAIL %s_kdone_latency got=%0d want=12", tag, lat);
      end
      checks++;
      if (ready !== 1'b1 || early_ready) begin
         failures++;
         $display("FAIL %s_kexp_ready got=%b early=%b want=1 at kdone only", tag, ready, early_ready);
      end
   endtask

   // Called at a negedge; returns in the done cycle so a following call is back-to-back.
   task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt, input int ld_at,
                          input string tag);
      int lat;
      ld = 1'b1; text_in = ct;
      exp_q.push_back(pt);
      @(negedge clk);
      ld = 1'b0; text_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL %s_ready_busy got=%b want=0", tag, ready);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 30) begin
         ld = (ld_at > 0 && lat == ld_at);
         @(negedge clk);
         lat++;
      end
      ld = 1'b0;
      last_pt = pt;
      checks++;
      if (lat != 11) begin
         failures++;
         $display("FAIL %s_done_latency got=%0d want=11", tag, lat);
      end
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_ready_at_done got=%b want=1", tag, ready);
      end
   endtask

   task automatic test_fips;
      load_key(KEY_C1, -1, "c1");
      decrypt(CT_C1, PT_C1, -1, "c1");
      load_key(KEY_B, -1, "appb");
      decrypt(CT_B, PT_B, -1, "appb");
   endtask

   task automatic test_ld_while_busy;
      load_key(KEY_C1, 4, "ld_in_kexp");
      decrypt(CT_C1, PT_C1, 3, "ld_in_run");
   endtask

   task automatic test_kld_same_cycle;
      load_key(KEY_B, 0, "kld_ld_same");
      decrypt(CT_B, PT_B, -1, "after_same");
   endtask

   task automatic test_kld_abort;
      int lat;
      load_key(KEY_C1, -1, "pre_abort");
      decrypt(CT_C1, PT_C1, -1, "pre_abort");
      ld = 1'b1; text_in = CT_B;
      @(negedge clk);
      ld = 1'b0;
      lat = 0;
      while (lat < 4) begin @(negedge clk); lat++; end
      load_key(KEY_B, -1, "abort");
      checks++;
      if (text_out !== last_pt) begin
         failures++;
         $display("FAIL abort_text_out got=%h want=%h", text_out, last_pt);
      end
      decrypt(CT_B, PT_B, -1, "after_abort");
   endtask

   task automatic test_rst_mid_run;
      int lat;
      ld = 1'b1; text_in = CT_B;
      @(negedge clk);
      ld = 1'b0;
      lat = 0;
      while (lat < 5) begin @(negedge clk); lat++; end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ready, kdone, done} !== 3'b000) begin
         failures++;
         $display("FAIL rst_run_flags got=%b want=000", {ready, kdone, done});
      end
      checks++;
      if (text_out !== 128'h0) begin
         failures++;
         $display("FAIL rst_run_text_out got=%h want=0", text_out);
      end
      rst = 1'b1;
      test_ld_ignored("post_rst");
      load_key(KEY_C1, -1, "recover");
      decrypt(CT_C1, PT_C1, -1, "recover");
   endtask

   task automatic test_loopback;
      logic [127:0] k, pt;
      for (int n = 0; n < 60; n++) begin
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         load_key(k, -1, "loop");
         for (int b = 0; b < 4; b++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            decrypt(tb_encrypt(k, pt), pt, -1, "loop");
         end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ld_ignored("no_key");
      test_fips();
      test_ld_while_busy();
      test_kld_same_cycle();
      test_kld_abort();
      test_rst_mid_run();
      test_loopback();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL outstanding_blocks got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
